// File: rtl/clf_pkg.sv
// rtl/clf_pkg.sv - shared types and default dataset dimensions for the classifier stream wrapper
package clf_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        OUT
    } state_t;

    // WW dataset defaults
    localparam int WW_WIDTH_A  = 4;
    localparam int WW_NUM_A    = 11;
    localparam int WW_OUTWIDTH = 13;

    localparam int DEF_SETTLE_CYC = 2;
    localparam int DEF_IDXW       = 16;

endpackage

// File: rtl/clf_feature_deser.sv
// rtl/clf_feature_deser.sv - feature slot register array with slot index and framing checks
module clf_feature_deser
    import clf_pkg::*;
#(
    parameter int WIDTH_A = WW_WIDTH_A,
    parameter int NUM_A   = WW_NUM_A
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [WIDTH_A-1:0]         s_data,
    input  logic                       s_last,
    output logic [NUM_A*WIDTH_A-1:0]   cls_inp,
    output logic                       done,
    output logic                       err
);

    localparam int IW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_A - 1);

    logic [IW-1:0]             idx_q;
    logic [NUM_A*WIDTH_A-1:0]  slots_q;
    logic                      at_last;
    logic                      abort;

    assign at_last = (idx_q == LAST_IDX);
    assign done    = load & at_last;
    assign abort   = load & s_last & ~at_last;
    // A short frame and a final feature without s_last are both framing errors
    assign err     = abort | (done & ~s_last);
    assign cls_inp = slots_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            slots_q <= '0;
        end else if (load) begin
            slots_q[int'(idx_q)*WIDTH_A +: WIDTH_A] <= s_data;
            if (at_last || s_last) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clf_stream_wrapper.sv
// rtl/clf_stream_wrapper.sv - clocked stream front/back end around a combinational classifier
module clf_stream_wrapper
    import clf_pkg::*;
#(
    parameter int WIDTH_A    = WW_WIDTH_A,
    parameter int NUM_A      = WW_NUM_A,
    parameter int OUTWIDTH   = WW_OUTWIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int IDXW       = DEF_IDXW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WIDTH_A-1:0]        s_data,
    input  logic                      s_last,
    output logic [NUM_A*WIDTH_A-1:0]  cls_inp,
    input  logic [OUTWIDTH-1:0]       cls_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OUTWIDTH-1:0]       m_data,
    output logic [IDXW-1:0]           m_index,
    output logic                      frame_err
);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 m_valid_d;
    logic [OUTWIDTH-1:0]  m_data_d;
    logic [IDXW-1:0]      m_index_d;
    logic                 frame_err_d;
    logic                 load;
    logic                 deser_done;
    logic                 deser_err;

    assign s_ready = (state_q == LOAD);
    assign load    = s_valid & s_ready;

    clf_feature_deser #(
        .WIDTH_A (WIDTH_A),
        .NUM_A   (NUM_A)
    ) u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .s_data  (s_data),
        .s_last  (s_last),
        .cls_inp (cls_inp),
        .done    (deser_done),
        .err     (deser_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid;
        m_data_d    = m_data;
        m_index_d   = m_index;
        frame_err_d = frame_err | deser_err;
        case (state_q)
            LOAD: begin
                if (deser_done) begin
                    state_d = SETTLE;
                    cnt_d   = 8'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                // cls_inp is frozen here, so the classifier output is stable at capture
                if (cnt_q == 8'd0) begin
                    m_data_d  = cls_out;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_index_d = m_index + 1'b1;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_valid   <= m_valid_d;
            m_data    <= m_data_d;
            m_index   <= m_index_d;
            frame_err <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_clf_stream_wrapper.sv
// tb/tb_clf_stream_wrapper.sv - scoreboard bench for clf_stream_wrapper with a sum-of-features classifier stub
module tb_clf_stream_wrapper;

    localparam int WA  = 4;
    localparam int NA  = 11;
    localparam int OW  = 13;
    localparam int SC  = 2;
    localparam int IW1 = 16;
    localparam int IW2 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic m_ready = 1'b0;
    logic [WA-1:0] s_data = '0;

    logic s_ready, s_ready2, m_valid, m_valid2, frame_err, frame_err2;
    logic [NA*WA-1:0] cls_inp, cls_inp2;
    logic [OW-1:0] cls_out, cls_out2, m_data, m_data2;
    logic [IW1-1:0] m_index;
    logic [IW2-1:0] m_index2;

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] stub(input logic [NA*WA-1:0] v);
        int s = 0;
        for (int i = 0; i < NA; i++) s += int'(v[i*WA +: WA]);
        return OW'(s);
    endfunction

    assign cls_out  = stub(cls_inp);
    assign cls_out2 = stub(cls_inp2);

    clf_stream_wrapper #(.WIDTH_A(WA), .NUM_A(NA), .OUTWIDTH(OW), .SETTLE_CYC(SC), .IDXW(IW1)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .cls_inp(cls_inp), .cls_out(cls_out), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .frame_err(frame_err)
    );

    clf_stream_wrapper #(.WIDTH_A(WA), .NUM_A(NA), .OUTWIDTH(OW), .SETTLE_CYC(SC), .IDXW(IW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
        .s_last(s_last), .cls_inp(cls_inp2), .cls_out(cls_out2), .m_valid(m_valid2),
        .m_ready(m_ready), .m_data(m_data2), .m_index(m_index2), .frame_err(frame_err2)
    );

    typedef struct {
        int          sum;
        int          idx;
        logic [NA*WA-1:0] vec;
        int          accept_edge;
    } exp_t;

    exp_t expq[$];
    int   frame[$];
    int   n_res = 0;
    bit   exp_err = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;
    int   rdy_mode = 0;
    int   fv[NA];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cycle);
        end
    endtask

    // Reference: a sample is complete after NUM_A accepted features; an early s_last drops it
    task automatic model_accept(input int d, input bit last);
        exp_t e;
        frame.push_back(d);
        if (frame.size() == NA) begin
            e.sum = 0;
            e.vec = '0;
            for (int i = 0; i < NA; i++) begin
                e.vec[i*WA +: WA] = WA'(frame[i]);
                e.sum += frame[i];
            end
            e.idx = n_res;
            e.accept_edge = cycle + 1;
            expq.push_back(e);
            n_res++;
            if (!last) exp_err = 1'b1;
            frame.delete();
        end else if (last) begin
            exp_err = 1'b1;
            frame.delete();
        end
    endtask

    task automatic send(input int d, input bit last);
        int  waited = 0;
        bit  done = 1'b0;
        s_valid = 1'b1;
        s_data  = WA'(d);
        s_last  = last;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(d, last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 100) begin
                    chk("send_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) send(fv[i], (i == n - 1) ? last_on_final : 1'b0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (expq.size() > 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_timeout", expq.size(), 0);
    endtask

    task automatic clear_model();
        expq.delete();
        frame.delete();
        n_res = 0;
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    initial begin
        bit               prev_valid = 1'b0;
        bit               prev_stall = 1'b0;
        logic [OW-1:0]    prev_data = '0;
        logic [IW1-1:0]   prev_idx = '0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (m_valid && !prev_valid && expq.size() > 0) begin
                    chk("latency", cycle, expq[0].accept_edge + SC);
                    chk("cls_inp", longint'(cls_inp), longint'(expq[0].vec));
                end
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, prev_data);
                    chk("stall_index", m_index, prev_idx);
                end
                if (m_valid && m_ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("m_data", m_data, e.sum);
                        chk("m_index", m_index, e.idx % (1 << IW1));
                        chk("m_valid_w2", m_valid2, 1);
                        chk("m_data_w2", m_data2, e.sum);
                        chk("m_index_w2", m_index2, e.idx % (1 << IW2));
                    end
                end
                prev_valid = m_valid;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_idx   = m_index;
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_cls_inp", longint'(cls_inp), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        rdy_mode = 0;
        for (int i = 0; i < NA; i++) fv[i] = i + 1;
        send_frame(NA, 1'b1);
        wait_drain();
        chk("t1_frame_err", frame_err, 0);

        rdy_mode = 2;
        for (int i = 0; i < NA; i++) fv[i] = 15;
        send_frame(NA, 1'b1);
        t = 0;
        while (!m_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("t2_valid_timeout", m_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("t2_stall_s_ready", s_ready, 0);
        end
        rdy_mode = 0;
        for (int i = 0; i < NA; i++) fv[i] = 0;
        send_frame(NA, 1'b1);
        wait_drain();

        do_reset();
        for (int i = 0; i < NA; i++) fv[i] = 2;
        send_frame(6, 1'b1);
        send_frame(NA, 1'b1);
        wait_drain();
        chk("t3_frame_err", frame_err, int'(exp_err));

        do_reset();
        for (int i = 0; i < NA; i++) fv[i] = int'($urandom_range(0, 15));
        send_frame(NA, 1'b0);
        wait_drain();
        chk("t4_frame_err", frame_err, int'(exp_err));

        do_reset();
        for (int i = 0; i < NA; i++) fv[i] = int'($urandom_range(0, 15));
        send_frame(NA, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_cls_inp", longint'(cls_inp), 0);
        chk("t5_s_ready", s_ready, 1);
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NA; i++) fv[i] = int'($urandom_range(0, 15));
        send_frame(NA, 1'b1);
        wait_drain();

        do_reset();
        rdy_mode = 1;
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < NA; i++) fv[i] = int'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) send_frame(int'($urandom_range(1, NA - 1)), 1'b1);
            else send_frame(NA, ($urandom_range(0, 7) != 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain();
        chk("rand_frame_err", frame_err, int'(exp_err));
        chk("rand_frame_err_w2", frame_err2, int'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
